// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 2-flop synchronizer, 3-sample majority vote, optional parity,
// 1/2 stop bits, valid/ready output. Define UART_RX_BREAK_DETECT_EN to report break frames on o_break.
module uart_rx_ovs #(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int TICK_DIV   = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy,
  output logic                 o_break
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SMP_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [SMP_W-1:0] SMP_A    = SMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SMP_W-1:0] SMP_B    = SMP_W'(OVERSAMPLE / 2);
  localparam logic [SMP_W-1:0] SMP_C    = SMP_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  localparam logic [2:0] WAIT  = 3'd5;

  logic                 rx_meta, rx_sync, rx_prev;
  logic [2:0]           state_reg;
  logic [DIV_W-1:0]     div_cnt;
  logic [SMP_W-1:0]     smp_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic                 smp_a_reg, smp_b_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_err_reg, frame_err_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 valid_reg, perr_out_reg, ferr_out_reg, overrun_reg, break_reg;

  logic tick, decide, bit_val, last_stop, first_stop_low, deliver, is_break, load;

  assign tick           = (state_reg != IDLE) && (div_cnt == DIV_LAST);
  assign decide         = tick && (smp_cnt == SMP_C);
  assign bit_val        = (smp_a_reg & smp_b_reg) | (smp_a_reg & rx_sync) | (smp_b_reg & rx_sync);
  assign last_stop      = (state_reg == STOP) && ((STOP_BITS == 1) || stop_cnt);
  // With two stop bits the frame error was latched on the first one.
  assign first_stop_low = stop_cnt ? frame_err_reg : ~bit_val;
  assign deliver        = decide && last_stop;

`ifdef UART_RX_BREAK_DETECT_EN
  logic par_bit_reg;
  assign is_break = deliver && first_stop_low && (shift_reg == '0) &&
                    ((PARITY == 0) || !par_bit_reg);
`else
  assign is_break = 1'b0;
`endif

  assign load = deliver && !is_break && (!valid_reg || i_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_prev       <= 1'b1;
      state_reg     <= IDLE;
      div_cnt       <= '0;
      smp_cnt       <= '0;
      bit_cnt       <= '0;
      stop_cnt      <= 1'b0;
      smp_a_reg     <= 1'b0;
      smp_b_reg     <= 1'b0;
      shift_reg     <= '0;
      par_err_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      par_bit_reg   <= 1'b0;
`endif
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (state_reg == IDLE) begin
        div_cnt <= '0;
        smp_cnt <= '0;
        if (rx_prev && !rx_sync)
          state_reg <= START;
      end else begin
        if (tick) begin
          div_cnt <= '0;
          smp_cnt <= (smp_cnt == SMP_LAST) ? '0 : smp_cnt + 1'b1;
          if (smp_cnt == SMP_A) smp_a_reg <= rx_sync;
          if (smp_cnt == SMP_B) smp_b_reg <= rx_sync;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        // Every bit is decided on its third vote sample; the sample counter keeps bit alignment.
        if (state_reg == WAIT) begin
          if (rx_sync) state_reg <= IDLE;
        end else if (decide) begin
          case (state_reg)
            START: begin
              bit_cnt   <= '0;
              state_reg <= bit_val ? IDLE : DATA;
            end
            DATA: begin
              shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                stop_cnt  <= 1'b0;
                state_reg <= (PARITY != 0) ? PAR : STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            PAR: begin
              par_err_reg <= (PARITY == 1) ? ~(^shift_reg ^ bit_val) : (^shift_reg ^ bit_val);
`ifdef UART_RX_BREAK_DETECT_EN
              par_bit_reg <= bit_val;
`endif
              state_reg   <= STOP;
            end
            STOP: begin
              if (!stop_cnt) frame_err_reg <= ~bit_val;
              if (last_stop) state_reg <= (bit_val && !is_break) ? IDLE : WAIT;
              else           stop_cnt  <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      perr_out_reg <= 1'b0;
      ferr_out_reg <= 1'b0;
      overrun_reg  <= 1'b0;
      break_reg    <= 1'b0;
    end else begin
      overrun_reg <= deliver && !is_break && valid_reg && !i_ready;
      break_reg   <= is_break;
      if (load) begin
        data_reg     <= shift_reg;
        perr_out_reg <= par_err_reg;
        ferr_out_reg <= first_stop_low;
        valid_reg    <= 1'b1;
      end else if (i_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign o_valid      = valid_reg;
  assign o_data       = data_reg;
  assign o_parity_err = perr_out_reg;
  assign o_frame_err  = ferr_out_reg;
  assign o_overrun    = overrun_reg;
  assign o_busy       = (state_reg != IDLE);
  assign o_break      = break_reg;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: an 8N1 instance and an 8E1 instance at 32 clocks per bit.
module tb_uart_rx_ovs;

  localparam int CLK_RATE = 3686400;
  localparam int BAUD     = 115200;
  localparam int OVS      = 16;
  localparam int BIT      = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  logic rx = 1'b1, rx_e = 1'b1, ready = 1'b1, ready_e = 1'b1;

  logic       valid, perr, ferr, ovr, busy, brk;
  logic [7:0] data;
  logic       valid_e, perr_e, ferr_e, ovr_e, busy_e, brk_e;
  logic [7:0] data_e;

  uart_rx_ovs #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .OVERSAMPLE(OVS),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .i_ready(ready),
    .o_valid(valid), .o_data(data), .o_parity_err(perr), .o_frame_err(ferr),
    .o_overrun(ovr), .o_busy(busy), .o_break(brk));

  uart_rx_ovs #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .OVERSAMPLE(OVS),
                .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_e), .i_ready(ready_e),
    .o_valid(valid_e), .o_data(data_e), .o_parity_err(perr_e), .o_frame_err(ferr_e),
    .o_overrun(ovr_e), .o_busy(busy_e), .o_break(brk_e));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int rises = 0, vhigh = 0, accepts = 0, ovr_cnt = 0, brk_cnt = 0, rise_cyc = 0;
  logic       valid_q = 1'b0;
  logic [7:0] acc_data = '0;
  logic       acc_pe = 1'b0, acc_fe = 1'b0;
  int         acc_e_cnt = 0;
  logic [7:0] acc_e_data = '0;
  logic       acc_e_pe = 1'b0;

  always @(negedge clk) begin
    valid_q <= valid;
    if (valid && !valid_q) begin
      rises    <= rises + 1;
      rise_cyc <= cyc;
    end
    if (valid) vhigh <= vhigh + 1;
    if (valid && ready) begin
      accepts  <= accepts + 1;
      acc_data <= data;
      acc_pe   <= perr;
      acc_fe   <= ferr;
      $display("[%0d] 8N1 word %02h pe=%0b fe=%0b", cyc, data, perr, ferr);
    end
    if (ovr) begin
      ovr_cnt <= ovr_cnt + 1;
      $display("[%0d] 8N1 overrun pulse", cyc);
    end
    if (brk) begin
      brk_cnt <= brk_cnt + 1;
      $display("[%0d] 8N1 break pulse", cyc);
    end
    if (valid_e && ready_e) begin
      acc_e_cnt  <= acc_e_cnt + 1;
      acc_e_data <= data_e;
      acc_e_pe   <= perr_e;
      $display("[%0d] 8E1 word %02h pe=%0b fe=%0b", cyc, data_e, perr_e, ferr_e);
    end
  end

  int t0 = 0;

  task automatic sync_in();
    @(posedge clk);
    #1;
  endtask

  // Drives n bits LSB first, one bit per BIT clocks; ends just after a rising edge.
  task automatic tx(input bit sel, input int n, input logic [15:0] pat);
    sync_in();
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      if (sel) rx_e = pat[i];
      else     rx   = pat[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_bits(input int n);
    rx   = 1'b1;
    rx_e = 1'b1;
    repeat (n * BIT) @(posedge clk);
    #1;
  endtask

  int r0, v0, a0, o0, b0, e0;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_valid", {31'b0, valid}, 0);
    chk_eq("rst_busy",  {31'b0, busy}, 0);
    chk_eq("rst_data",  {24'b0, data}, 0);
    chk_eq("rst_ovr",   {31'b0, ovr}, 0);
    chk_eq("rst_brk",   {31'b0, brk}, 0);
    sync_in();
    rst_n = 1'b1;
    idle_bits(1);

    // 1: 8N1 0xA5, ready high
    r0 = rises; v0 = vhigh;
    tx(0, 10, {6'b0, 1'b1, 8'hA5, 1'b0});
    idle_bits(2);
    chk_eq("t1_rises", rises - r0, 1);
    chk_eq("t1_vcycles", vhigh - v0, 1);
    chk_eq("t1_data", {24'b0, acc_data}, 32'hA5);
    chk_eq("t1_pe", {31'b0, acc_pe}, 0);
    chk_eq("t1_fe", {31'b0, acc_fe}, 0);
    chk_eq("t1_latency", rise_cyc - t0, 311);

    // 2: 8E1 0x03 with wrong then correct parity
    e0 = acc_e_cnt;
    tx(1, 11, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0});
    idle_bits(2);
    chk_eq("t2_bad_data", {24'b0, acc_e_data}, 32'h03);
    chk_eq("t2_bad_pe", {31'b0, acc_e_pe}, 1);
    tx(1, 11, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0});
    idle_bits(2);
    chk_eq("t2_ok_data", {24'b0, acc_e_data}, 32'h03);
    chk_eq("t2_ok_pe", {31'b0, acc_e_pe}, 0);
    chk_eq("t2_count", acc_e_cnt - e0, 2);

    // 3: 6-tick low glitch
    r0 = rises;
    sync_in();
    rx = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_eq("t3_busy_hi", {31'b0, busy}, 1);
    repeat (7) @(posedge clk);
    #1;
    idle_bits(2);
    @(negedge clk);
    chk_eq("t3_busy_lo", {31'b0, busy}, 0);
    chk_eq("t3_no_valid", rises - r0, 0);

    // 4: overrun with ready low
    sync_in();
    ready = 1'b0;
    o0 = ovr_cnt; a0 = accepts;
    tx(0, 10, {6'b0, 1'b1, 8'h11, 1'b0});
    idle_bits(1);
    tx(0, 10, {6'b0, 1'b1, 8'h22, 1'b0});
    idle_bits(1);
    @(negedge clk);
    chk_eq("t4_valid", {31'b0, valid}, 1);
    chk_eq("t4_data", {24'b0, data}, 32'h11);
    chk_eq("t4_ovr", ovr_cnt - o0, 1);
    sync_in();
    ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("t4_acc_data", {24'b0, acc_data}, 32'h11);
    chk_eq("t4_acc_cnt", accepts - a0, 1);
    chk_eq("t4_valid_clr", {31'b0, valid}, 0);

    // 5a: framing error on 0x5A, then line held low
    r0 = rises;
    tx(0, 10, {6'b0, 1'b0, 8'h5A, 1'b0});
    repeat (3 * BIT) @(posedge clk);
    @(negedge clk);
    chk_eq("t5_rises", rises - r0, 1);
    chk_eq("t5_data", {24'b0, acc_data}, 32'h5A);
    chk_eq("t5_fe", {31'b0, acc_fe}, 1);
    chk_eq("t5_pe", {31'b0, acc_pe}, 0);
    chk_eq("t5_wait_busy", {31'b0, busy}, 1);
    sync_in();
    idle_bits(2);
    @(negedge clk);
    chk_eq("t5_idle_busy", {31'b0, busy}, 0);
    chk_eq("t5_no_retrig", rises - r0, 1);

    // 5b: 20 bit times low
    r0 = rises; b0 = brk_cnt;
    sync_in();
    rx = 1'b0;
    repeat (20 * BIT) @(posedge clk);
    #1;
    idle_bits(2);
    @(negedge clk);
`ifdef UART_RX_BREAK_DETECT_EN
    chk_eq("t5_brk", brk_cnt - b0, 1);
    chk_eq("t5_brk_novalid", rises - r0, 0);
`else
    chk_eq("t5_brk", brk_cnt - b0, 0);
    chk_eq("t5_brk_rises", rises - r0, 1);
    chk_eq("t5_brk_data", {24'b0, acc_data}, 0);
    chk_eq("t5_brk_fe", {31'b0, acc_fe}, 1);
`endif

    // 6: reset mid-DATA of 0xFF, then clean 0x3C
    r0 = rises;
    tx(0, 5, {6'b0, 1'b1, 8'hFF, 1'b0});
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("t6_valid", {31'b0, valid}, 0);
    chk_eq("t6_busy", {31'b0, busy}, 0);
    chk_eq("t6_data", {24'b0, data}, 0);
    chk_eq("t6_fe", {31'b0, ferr}, 0);
    sync_in();
    rst_n = 1'b1;
    idle_bits(1);
    tx(0, 10, {6'b0, 1'b1, 8'h3C, 1'b0});
    idle_bits(2);
    chk_eq("t6_rises", rises - r0, 1);
    chk_eq("t6_acc_data", {24'b0, acc_data}, 32'h3C);
    chk_eq("t6_acc_fe", {31'b0, acc_fe}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
